// File: rtl/adder_share_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// adder_share_arbiter_pkg
// Shared constants and types for the adder-sharing arbiter:
//   - OPW            : operand / sum width of the shared adder
//   - ST_IDLE/ADD/RESP : FSM state encoding (2-bit)
//   - operand_t      : latched operand bundle handed to the adder
//   - wrap_inc       : modulo-n increment used for the round-robin pointer
// ----------------------------------------------------------------------------
package adder_share_arbiter_pkg;

    localparam int unsigned OPW = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef struct packed {
        logic [OPW-1:0] a;
        logic [OPW-1:0] b;
        logic           cin;
    } operand_t;

    // (idx + 1) mod n, written without a divider.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/adder_share_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin pick: the first set bit of `valid` found when
// searching ptr, ptr+1, ... wrapping at NREQ.
// Ports:
//   valid : request vector
//   ptr   : search start index (0..NREQ-1)
//   grant : one-hot winner (all zero when no request)
//   idx   : index of the winner (0 when no request)
//   any   : at least one request present
// ----------------------------------------------------------------------------
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        // Upper segment first: ptr .. NREQ-1.
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!any && valid[i] && (i >= int'(ptr))) begin
                any      = 1'b1;
                grant[i] = 1'b1;
                idx      = IDW'(i);
            end
        end
        // Then the wrapped segment: 0 .. ptr-1.
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!any && valid[i] && (i < int'(ptr))) begin
                any      = 1'b1;
                grant[i] = 1'b1;
                idx      = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/cla16ripple.sv
// ----------------------------------------------------------------------------
// cla16ripple
// 16-bit adder built from four 4-bit carry-lookahead groups with the group
// carries rippling from group to group.
// Ports:
//   a, b  : 16-bit operands
//   cin   : carry-in
//   sum   : 16-bit sum (mod 2^16)
//   cout  : carry-out of bit 15
// ----------------------------------------------------------------------------
module cla16ripple (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [3:0] p;
    logic [3:0] g;
    logic       c0;
    logic       c1;
    logic       c2;
    logic       c3;
    logic       c4;

    always_comb begin
        p   = '0;
        g   = '0;
        c1  = 1'b0;
        c2  = 1'b0;
        c3  = 1'b0;
        c4  = 1'b0;
        sum = '0;
        c0  = cin;
        for (int gi = 0; gi < 4; gi++) begin
            p  = a[gi*4 +: 4] ^ b[gi*4 +: 4];
            g  = a[gi*4 +: 4] & b[gi*4 +: 4];
            // Lookahead carries inside the group, all from the group carry-in.
            c1 = g[0] | (p[0] & c0);
            c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
            c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
            c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & c0);
            sum[gi*4 +: 4] = p ^ {c3, c2, c1, c0};
            // Group carry ripples into the next group.
            c0 = c4;
        end
        cout = c0;
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// ----------------------------------------------------------------------------
// adder_share_arbiter
// Shares one cla16ripple adder among NREQ requesters. Each operation walks
// IDLE (grant + latch) -> ADD (adder sees latched operands, result
// registered) -> RESP (hold result until respReady) -> IDLE.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   reqValid    : per-requester valid
//   reqReady    : one-hot grant strobe, only in IDLE
//   reqA, reqB  : packed 16-bit operands, requester i at [16i+15:16i]
//   reqCin      : per-requester carry-in
//   respValid   : result valid (high in RESP)
//   respReady   : result consumer ready
//   respSum     : registered 16-bit sum
//   respCout    : registered carry-out
//   respId      : index of the served requester
//   busy        : high whenever not IDLE
// ----------------------------------------------------------------------------
module adder_share_arbiter
    import adder_share_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     reqValid,
    output logic [NREQ-1:0]     reqReady,
    input  logic [OPW*NREQ-1:0] reqA,
    input  logic [OPW*NREQ-1:0] reqB,
    input  logic [NREQ-1:0]     reqCin,
    output logic                respValid,
    input  logic                respReady,
    output logic [OPW-1:0]      respSum,
    output logic                respCout,
    output logic [IDW-1:0]      respId,
    output logic                busy
);

    logic [1:0]      state_q;
    logic [1:0]      state_d;
    logic [IDW-1:0]  rr_ptr_q;
    logic [IDW-1:0]  rr_ptr_d;
    operand_t        op_q;
    operand_t        op_sel;
    logic [IDW-1:0]  op_id_q;
    logic [OPW-1:0]  resp_sum_q;
    logic            resp_cout_q;
    logic [IDW-1:0]  resp_id_q;

    logic [NREQ-1:0] pick_oh;
    logic [IDW-1:0]  pick_idx;
    logic            pick_any;
    logic            grant_fire;

    logic [OPW-1:0]  add_sum;
    logic            add_cout;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .valid (reqValid),
        .ptr   (rr_ptr_q),
        .grant (pick_oh),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    cla16ripple u_adder (
        .a    (op_q.a),
        .b    (op_q.b),
        .cin  (op_q.cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign grant_fire = (state_q == ST_IDLE) && pick_any;

    // Operand mux driven by the one-hot pick, so no variable part-select.
    always_comb begin
        op_sel = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (pick_oh[i]) begin
                op_sel.a   = reqA[i*OPW +: OPW];
                op_sel.b   = reqB[i*OPW +: OPW];
                op_sel.cin = reqCin[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d  = ST_ADD;
                    rr_ptr_d = IDW'(wrap_inc(32'(pick_idx), NREQ));
                end
            end
            ST_ADD: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (respReady) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            op_id_q <= '0;
        end else if (grant_fire) begin
            op_q    <= op_sel;
            op_id_q <= pick_idx;
        end
    end

    // Result registers load only on the ADD edge, so they stay frozen in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_sum_q  <= '0;
            resp_cout_q <= 1'b0;
            resp_id_q   <= '0;
        end else if (state_q == ST_ADD) begin
            resp_sum_q  <= add_sum;
            resp_cout_q <= add_cout;
            resp_id_q   <= op_id_q;
        end
    end

    // Gated by rst_n so the strobe is low while reset is held, even with
    // requests pending.
    assign reqReady  = (rst_n && (state_q == ST_IDLE)) ? pick_oh : '0;
    assign respValid = (state_q == ST_RESP);
    assign respSum   = resp_sum_q;
    assign respCout  = resp_cout_q;
    assign respId    = resp_id_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adder_share_arbiter.sv
// ----------------------------------------------------------------------------
// tb_adder_share_arbiter
// Directed and randomized checks of adder_share_arbiter against a
// transaction-level reference: round-robin winner chosen from a pointer
// integer, expected result computed as plain 17-bit arithmetic A+B+Cin.
// ----------------------------------------------------------------------------
module tb_adder_share_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NREQ-1:0] reqValid;
    logic [NREQ-1:0] reqReady;
    logic [63:0]     reqA;
    logic [63:0]     reqB;
    logic [NREQ-1:0] reqCin;
    logic            respValid;
    logic            respReady;
    logic [15:0]     respSum;
    logic            respCout;
    logic [IDW-1:0]  respId;
    logic            busy;

    int total = 0;
    int bad   = 0;
    int mptr  = 0;

    logic [15:0] a_arr   [NREQ];
    logic [15:0] b_arr   [NREQ];
    logic        cin_arr [NREQ];

    adder_share_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .reqValid  (reqValid),
        .reqReady  (reqReady),
        .reqA      (reqA),
        .reqB      (reqB),
        .reqCin    (reqCin),
        .respValid (respValid),
        .respReady (respReady),
        .respSum   (respSum),
        .respCout  (respCout),
        .respId    (respId),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference round-robin: first valid index at or after the pointer.
    function automatic int ref_pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic drive_ops();
        for (int i = 0; i < NREQ; i++) begin
            reqA[i*16 +: 16] = a_arr[i];
            reqB[i*16 +: 16] = b_arr[i];
            reqCin[i]        = cin_arr[i];
        end
    endtask

    task automatic set_op(input int i, input int a, input int b, input int c);
        a_arr[i]   = 16'(a);
        b_arr[i]   = 16'(b);
        cin_arr[i] = c[0];
    endtask

    // One full operation from an IDLE sample point back to the next IDLE
    // sample point; `stall` RESP edges are taken with respReady low.
    task automatic run_op(input logic [NREQ-1:0] v, input int stall);
        int          g;
        logic [16:0] exp;
        reqValid  = v;
        drive_ops();
        respReady = (stall == 0);
        #1;
        g   = ref_pick(v, mptr);
        exp = 17'(a_arr[g]) + 17'(b_arr[g]) + 17'(cin_arr[g]);
        chk("grant_onehot", 32'(reqReady), 32'(1) << g);
        chk("busy_idle", 32'(busy), 0);
        mptr = (g + 1) % NREQ;
        @(posedge clk); #1;
        chk("busy_add", 32'(busy), 1);
        chk("ready_add", 32'(reqReady), 0);
        chk("valid_add", 32'(respValid), 0);
        @(posedge clk); #1;
        chk("resp_valid", 32'(respValid), 1);
        chk("resp_sum", 32'(respSum), 32'(exp[15:0]));
        chk("resp_cout", 32'(respCout), 32'(exp[16]));
        chk("resp_id", 32'(respId), 32'(g));
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk("stall_valid", 32'(respValid), 1);
            chk("stall_sum", 32'(respSum), 32'(exp[15:0]));
            chk("stall_id", 32'(respId), 32'(g));
            chk("stall_ready", 32'(reqReady), 0);
            if (s == stall - 1) respReady = 1'b1;
        end
        @(posedge clk); #1;
        chk("done_valid", 32'(respValid), 0);
        chk("done_busy", 32'(busy), 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        reqValid  = '0;
        reqA      = '0;
        reqB      = '0;
        reqCin    = '0;
        respReady = 1'b0;
        for (int i = 0; i < NREQ; i++) set_op(i, 0, 0, 0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(reqReady), 0);
        chk("rst_valid", 32'(respValid), 0);
        chk("rst_sum", 32'(respSum), 0);
        chk("rst_cout", 32'(respCout), 0);
        chk("rst_id", 32'(respId), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;

        // Only requester 1: 414 + 1036 = 1450
        set_op(1, 414, 1036, 0);
        run_op(4'b0010, 0);

        // Requester 0, all-ones with carry in
        set_op(0, 65535, 65535, 1);
        run_op(4'b0001, 0);

        // Idle cycle: no grant, pointer unchanged
        reqValid = '0;
        #1;
        chk("idle_ready", 32'(reqReady), 0);
        @(posedge clk); #1;
        chk("idle_busy", 32'(busy), 0);

        // Bring the pointer back to 0 via requester 3 (tests the wrap)
        set_op(3, 1, 2, 1);
        run_op(4'b1000, 0);

        // All four persistent, 0x8000 + 0x8000: ids 0,1,2,3,0
        for (int i = 0; i < NREQ; i++) set_op(i, 32768, 32768, 0);
        for (int n = 0; n < 5; n++) begin
            chk("rr_order", 32'(ref_pick(4'b1111, mptr)), 32'(n % NREQ));
            run_op(4'b1111, 0);
        end

        // Requesters 0 and 2 persistent: alternating service
        set_op(0, 100, 200, 1);
        set_op(2, 5045, 45042, 0);
        for (int n = 0; n < 4; n++) run_op(4'b0101, 0);

        // Backpressure: respReady low for 5 RESP cycles
        set_op(3, 12345, 54321, 1);
        run_op(4'b1000, 5);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                reqValid = '0;
                #1;
                chk("rand_idle_ready", 32'(reqReady), 0);
                @(posedge clk); #1;
                chk("rand_idle_busy", 32'(busy), 0);
            end else begin
                for (int i = 0; i < NREQ; i++) begin
                    set_op(i, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                           int'($urandom_range(0, 1)));
                end
                run_op(4'($urandom_range(1, 15)), int'($urandom_range(0, 2)));
            end
        end

        // Reset during ADD: pointer must restart at 0
        set_op(1, 7, 8, 0);
        set_op(3, 9, 10, 0);
        run_op(4'b0010, 0);
        set_op(2, 11, 22, 1);
        reqValid = 4'b0100;
        drive_ops();
        respReady = 1'b1;
        #1;
        chk("pre_rst_grant", 32'(reqReady), 32'b0100);
        @(posedge clk); #1;
        chk("pre_rst_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_ready", 32'(reqReady), 0);
        chk("midrst_valid", 32'(respValid), 0);
        chk("midrst_sum", 32'(respSum), 0);
        chk("midrst_id", 32'(respId), 0);
        mptr = 0;
        @(posedge clk); #1;
        chk("midrst_noresp", 32'(respValid), 0);
        rst_n = 1'b1;
        run_op(4'b1010, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
